// File: rtl/rf_writeback_queue.sv
// ---------------------------------------------------------------------------
// rf_writeback_queue
//
// Purpose:
//   Writer-side front end for the 32x32 register file write port. Completed
//   results arrive from the ALU and from the memory load path, each over a
//   valid/ready handshake. They are buffered in a small in-order FIFO and
//   drained one entry per cycle into the register file. Per-register busy
//   flags let operand fetch stall on registers that still have a pending
//   write.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   asynchronous, active-low; 0 clears all state at once
//   alu_valid  in   ALU result valid
//   alu_rd     in   ALU destination register       [ADDR_W]
//   alu_data   in   ALU result                     [DATA_W]
//   alu_ready  out  ALU result accepted this cycle
//   mem_valid  in   load result valid
//   mem_rd     in   load destination register      [ADDR_W]
//   mem_data   in   load result                    [DATA_W]
//   mem_ready  out  load result accepted this cycle
//   Dc         out  register file write data       [DATA_W]
//   write      out  register file write enable
//   rd         out  register file write index      [ADDR_W]
//   rs1, rs2   in   operand indices to check       [ADDR_W]
//   busy1/2    out  a pending write to rs1/rs2 exists
//   count      out  current occupancy              [$clog2(DEPTH)+1]
// ---------------------------------------------------------------------------
module rf_writeback_queue #(
   parameter int DEPTH   = 4,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter bit DROP_R0 = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alu_valid,
   input  logic [ADDR_W-1:0]        alu_rd,
   input  logic [DATA_W-1:0]        alu_data,
   output logic                     alu_ready,
   input  logic                     mem_valid,
   input  logic [ADDR_W-1:0]        mem_rd,
   input  logic [DATA_W-1:0]        mem_data,
   output logic                     mem_ready,
   output logic [DATA_W-1:0]        Dc,
   output logic                     write,
   output logic [ADDR_W-1:0]        rd,
   input  logic [ADDR_W-1:0]        rs1,
   input  logic [ADDR_W-1:0]        rs2,
   output logic                     busy1,
   output logic                     busy2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_entryRd   [DEPTH];
   logic [DATA_W-1:0] r_entryData [DEPTH];
   logic [DEPTH-1:0]  r_entryValid;
   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic [CNT_W-1:0]  r_count;

   logic [CNT_W-1:0]  w_free;
   logic              w_memPush;
   logic              w_aluPush;
   logic              w_memEnq;
   logic              w_aluEnq;
   logic              w_pop;
   logic [PTR_W-1:0]  w_aluSlot;

   assign count = r_count;

   // Handshake readiness comes only from the occupancy registered at the
   // start of the cycle, so a pop in this same cycle never frees a slot for
   // an incoming result. The load path wins the last free slot: the ALU is
   // only held off when exactly one slot remains and a load wants it.
   always_comb begin
      w_free    = CNT_W'(DEPTH) - r_count;
      mem_ready = (w_free >= CNT_W'(1));
      alu_ready = (w_free >= CNT_W'(2)) | ((w_free == CNT_W'(1)) & ~mem_valid);
   end

   // A transfer completes whenever valid meets ready. Results aimed at x0
   // still complete their handshake when dropping is enabled, but they never
   // occupy a slot. When both producers enqueue together the load is older,
   // so it takes the write pointer slot and the ALU result lands one behind.
   always_comb begin
      w_memPush = mem_valid & mem_ready;
      w_aluPush = alu_valid & alu_ready;
      w_memEnq  = w_memPush & ~(DROP_R0 & (mem_rd == '0));
      w_aluEnq  = w_aluPush & ~(DROP_R0 & (alu_rd == '0));
      w_aluSlot = r_wrPtr + PTR_W'(w_memEnq);
      w_pop     = (r_count != '0);
   end

   // FIFO state. The register file always accepts, so any non-empty cycle
   // retires the head. Pushes only ever target free slots, which keeps the
   // pop clear and push set on different entries. Pointers wrap naturally
   // because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wrPtr      <= '0;
         r_rdPtr      <= '0;
         r_count      <= '0;
         r_entryValid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_entryRd[i]   <= '0;
            r_entryData[i] <= '0;
         end
      end else begin
         if (w_pop) begin
            r_entryValid[r_rdPtr] <= 1'b0;
            r_rdPtr               <= r_rdPtr + PTR_W'(1);
         end
         if (w_memEnq) begin
            r_entryRd[r_wrPtr]    <= mem_rd;
            r_entryData[r_wrPtr]  <= mem_data;
            r_entryValid[r_wrPtr] <= 1'b1;
         end
         if (w_aluEnq) begin
            r_entryRd[w_aluSlot]    <= alu_rd;
            r_entryData[w_aluSlot]  <= alu_data;
            r_entryValid[w_aluSlot] <= 1'b1;
         end
         r_wrPtr <= r_wrPtr + PTR_W'(w_memEnq) + PTR_W'(w_aluEnq);
         r_count <= r_count + CNT_W'(w_memEnq) + CNT_W'(w_aluEnq) - CNT_W'(w_pop);
      end
   end

   // The write port simply mirrors the head entry. When the queue is empty
   // the index and data are forced to zero so the register file sees a
   // quiet bus.
   always_comb begin
      write = (r_count != '0);
      rd    = '0;
      Dc    = '0;
      if (write) begin
         rd = r_entryRd[r_rdPtr];
         Dc = r_entryData[r_rdPtr];
      end
   end

   // Busy flags scan every occupied slot, including the head that is being
   // retired this cycle; results pushed this cycle only show up next cycle.
   // x0 is never reported busy when writes to it are discarded.
   always_comb begin
      busy1 = 1'b0;
      busy2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_entryValid[i] && (r_entryRd[i] == rs1)) busy1 = 1'b1;
         if (r_entryValid[i] && (r_entryRd[i] == rs2)) busy2 = 1'b1;
      end
      if (DROP_R0 && (rs1 == '0)) busy1 = 1'b0;
      if (DROP_R0 && (rs2 == '0)) busy2 = 1'b0;
   end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// ---------------------------------------------------------------------------
// tb_rf_writeback_queue
//
// Purpose:
//   Self-checking bench for rf_writeback_queue. A reference queue of pending
//   writes is kept in the bench, and every output of the block is compared
//   against it once per cycle, between clock edges.
// ---------------------------------------------------------------------------
module tb_rf_writeback_queue;

   localparam int DEPTH   = 4;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 5;
   localparam bit DROP_R0 = 1'b1;

   typedef struct {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic                  clk;
   logic                  reset;
   logic                  alu_valid;
   logic [ADDR_W-1:0]     alu_rd;
   logic [DATA_W-1:0]     alu_data;
   logic                  alu_ready;
   logic                  mem_valid;
   logic [ADDR_W-1:0]     mem_rd;
   logic [DATA_W-1:0]     mem_data;
   logic                  mem_ready;
   logic [DATA_W-1:0]     Dc;
   logic                  write;
   logic [ADDR_W-1:0]     rd;
   logic [ADDR_W-1:0]     rs1;
   logic [ADDR_W-1:0]     rs2;
   logic                  busy1;
   logic                  busy2;
   logic [$clog2(DEPTH):0] count;

   entry_t modelQ[$];
   int     checks = 0;
   int     errors = 0;

   rf_writeback_queue #(
      .DEPTH   (DEPTH),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .DROP_R0 (DROP_R0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .mem_valid (mem_valid),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .Dc        (Dc),
      .write     (write),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .busy1     (busy1),
      .busy2     (busy2),
      .count     (count)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: count it, and report tag, observed and expected on a miss.
   task automatic checkValue(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Compare every output against what the pending-write list implies for
   // the current inputs.
   task automatic checkOutput();
      int         freeSlots;
      logic       expBusy1;
      logic       expBusy2;
      freeSlots = DEPTH - modelQ.size();
      expBusy1  = 1'b0;
      expBusy2  = 1'b0;
      foreach (modelQ[i]) begin
         if (modelQ[i].rd == rs1) expBusy1 = 1'b1;
         if (modelQ[i].rd == rs2) expBusy2 = 1'b1;
      end
      if (DROP_R0 && rs1 == 0) expBusy1 = 1'b0;
      if (DROP_R0 && rs2 == 0) expBusy2 = 1'b0;
      checkValue("count", 32'(count), 32'(modelQ.size()));
      checkValue("write", 32'(write), 32'(modelQ.size() != 0));
      checkValue("rd", 32'(rd), (modelQ.size() != 0) ? 32'(modelQ[0].rd) : 32'd0);
      checkValue("Dc", Dc, (modelQ.size() != 0) ? modelQ[0].data : 32'd0);
      checkValue("mem_ready", 32'(mem_ready), 32'(freeSlots >= 1));
      checkValue("alu_ready", 32'(alu_ready),
                 32'((freeSlots >= 2) || (freeSlots == 1 && !mem_valid)));
      checkValue("busy1", 32'(busy1), 32'(expBusy1));
      checkValue("busy2", 32'(busy2), 32'(expBusy2));
   endtask

   // Drive one cycle of inputs at the falling edge, check the outputs, then
   // advance the pending-write list to match the coming rising edge: the
   // head retires, then the load and the ALU result join in that order.
   task automatic applyStimulus(input logic mv, input logic [ADDR_W-1:0] mrd,
                                input logic [DATA_W-1:0] md, input logic av,
                                input logic [ADDR_W-1:0] ard,
                                input logic [DATA_W-1:0] ad,
                                input logic [ADDR_W-1:0] r1,
                                input logic [ADDR_W-1:0] r2);
      int     freeSlots;
      logic   memXfer;
      logic   aluXfer;
      entry_t e;
      @(negedge clk);
      mem_valid = mv;  mem_rd = mrd;  mem_data = md;
      alu_valid = av;  alu_rd = ard;  alu_data = ad;
      rs1 = r1;        rs2 = r2;
      #1;
      checkOutput();
      freeSlots = DEPTH - modelQ.size();
      memXfer   = mv && (freeSlots >= 1);
      aluXfer   = av && ((freeSlots >= 2) || (freeSlots == 1 && !mv));
      if (modelQ.size() != 0) void'(modelQ.pop_front());
      if (memXfer && !(DROP_R0 && mrd == 0)) begin
         e.rd = mrd;  e.data = md;  modelQ.push_back(e);
      end
      if (aluXfer && !(DROP_R0 && ard == 0)) begin
         e.rd = ard;  e.data = ad;  modelQ.push_back(e);
      end
   endtask

   task automatic idleStep(input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, r1, r2);
   endtask

   initial begin
      reset     = 1'b0;
      alu_valid = 1'b0;  alu_rd = '0;  alu_data = '0;
      mem_valid = 1'b0;  mem_rd = '0;  mem_data = '0;
      rs1 = '0;  rs2 = '0;

      // Reset held for two cycles; the idle state must be visible during it.
      repeat (2) @(negedge clk);
      #1;
      checkOutput();
      reset = 1'b1;

      // Idle after reset.
      repeat (5) idleStep(5'd5, 5'd3);

      // Single ALU push, then its commit, then empty again.
      applyStimulus(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
      idleStep(5'd5, 5'd6);
      checkValue("alu_single_busy1", 32'(busy1), 32'd1);
      idleStep(5'd5, 5'd6);

      // Simultaneous load and ALU result to the same register: load first.
      applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, 5'd3);
      idleStep(5'd3, 5'd4);
      checkValue("simul_first_Dc", Dc, 32'h11);
      idleStep(5'd3, 5'd4);
      checkValue("simul_second_Dc", Dc, 32'h22);
      idleStep(5'd3, 5'd4);

      // Back-pressure: reach three entries, then offer both producers.
      applyStimulus(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 5'd1, 5'd2);
      applyStimulus(1'b1, 5'd4, 32'hA4, 1'b1, 5'd6, 32'hA6, 5'd4, 5'd6);
      applyStimulus(1'b1, 5'd7, 32'hA7, 1'b1, 5'd8, 32'hA8, 5'd7, 5'd8);
      checkValue("bp_alu_ready", 32'(alu_ready), 32'd0);
      applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'hA9, 5'd8, 5'd9);
      repeat (4) idleStep(5'd9, 5'd7);

      // Register-0 results complete but vanish.
      applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd0);
      applyStimulus(1'b1, 5'd0, 32'h66, 1'b0, '0, '0, 5'd0, 5'd0);
      idleStep(5'd0, 5'd0);
      checkValue("r0_write", 32'(write), 32'd0);

      // Mid-operation reset with three queued entries, dropped between edges.
      applyStimulus(1'b1, 5'd10, 32'hB0, 1'b1, 5'd11, 32'hB1, 5'd10, 5'd11);
      applyStimulus(1'b1, 5'd12, 32'hB2, 1'b1, 5'd13, 32'hB3, 5'd12, 5'd13);
      @(posedge clk);
      #2;
      mem_valid = 1'b0;  alu_valid = 1'b0;
      #1;
      checkValue("pre_reset_count", 32'(count), 32'd3);
      reset = 1'b0;
      #1;
      modelQ.delete();
      checkValue("async_reset_write", 32'(write), 32'd0);
      checkValue("async_reset_count", 32'(count), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (4) idleStep(5'd12, 5'd13);

      // Randomized traffic over a small register range for collisions and x0.
      for (int n = 0; n < 400; n++) begin
         applyStimulus(($urandom_range(0, 99) < 65), 5'($urandom_range(0, 7)), $urandom,
                       ($urandom_range(0, 99) < 65), 5'($urandom_range(0, 7)), $urandom,
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      repeat (6) idleStep(5'd1, 5'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
